// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the pipelined MIPS core: word RAM plus an MMIO block holding
// a cycle counter, a one-shot timer and an output FIFO. Define DMEM_TIMER_IRQ_EN for a registered timer irq.
module mips_dmem_responder #(
  parameter int          RAM_AW     = 6,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] OFF_CYCLE = 8'h00;
  localparam logic [7:0] OFF_TIMER = 8'h04;
  localparam logic [7:0] OFF_TSTAT = 8'h08;
  localparam logic [7:0] OFF_OUT   = 8'h0C;
  localparam logic [7:0] OFF_OSTAT = 8'h10;

  logic [31:0] ram_q [2**RAM_AW];
  logic [31:0] fifo_mem_q [FIFO_DEPTH];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] timer_q, timer_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  logic        ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic              is_mmio;
  logic [7:0]        off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_ram, wr_timer, wr_tstat, wr_ostat, push_req;
  logic              fifo_full, fifo_empty, pop, push_ok, expire_set;
  logic              unused_addr;

  // Byte-lane bits and the offset's upper byte never participate in decode.
  assign unused_addr = ^{memaddr[15:8], memaddr[1:0]};

  assign is_mmio  = (memaddr[31:16] == MMIO_HI);
  assign off      = {memaddr[7:2], 2'b00};
  assign ram_idx  = memaddr[RAM_AW+1:2];
  assign wr_ram   = memwrite && !is_mmio;
  assign wr_timer = memwrite && is_mmio && (off == OFF_TIMER);
  assign wr_tstat = memwrite && is_mmio && (off == OFF_TSTAT);
  assign wr_ostat = memwrite && is_mmio && (off == OFF_OSTAT);
  assign push_req = memwrite && is_mmio && (off == OFF_OUT);

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_mem_q[rd_ptr_q];
  assign pop        = tx_valid && tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_comb begin
    cycle_d    = cycle_q + 32'd1;
    timer_d    = timer_q;
    running_d  = running_q;
    expire_set = 1'b0;
    if (wr_timer) begin
      timer_d   = memwritedata;
      running_d = (memwritedata != 32'd0);
    end else if (running_q) begin
      timer_d = timer_q - 32'd1;
      if (timer_q == 32'd1) begin
        running_d  = 1'b0;
        expire_set = 1'b1;
      end
    end
    // A fresh expiry outranks a W1C in the same cycle.
    expired_d = (expired_q && !(wr_tstat && memwritedata[0])) || expire_set;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    ovf_d      = (ovf_q && !(wr_ostat && memwritedata[2])) ||
                 (push_req && fifo_full && !pop);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (pop && !push_ok) fifo_cnt_d = fifo_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q    <= '0;
      timer_q    <= '0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      timer_q    <= timer_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage arrays carry no reset so RAM survives reset_n.
  always_ff @(posedge clk) begin
    if (wr_ram)  ram_q[ram_idx] <= memwritedata;
    if (push_ok) fifo_mem_q[wr_ptr_q] <= memwritedata;
  end

  always_comb begin
    memreaddata = 32'd0;
    if (is_mmio) begin
      case (off)
        OFF_CYCLE: memreaddata = cycle_q;
        OFF_TIMER: memreaddata = timer_q;
        OFF_TSTAT: memreaddata = {30'd0, running_q, expired_q};
        OFF_OSTAT: memreaddata = {16'd0, 8'(fifo_cnt_q), 5'd0, ovf_q, fifo_empty, fifo_full};
        default:   memreaddata = 32'd0;
      endcase
    end else begin
      memreaddata = ram_q[ram_idx];
    end
  end

`ifdef DMEM_TIMER_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = expired_q;
  assign irq   = irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: RAM, cycle counter, timer/irq, output FIFO and async reset.
module tb_mips_dmem_responder;

  localparam logic [31:0] A_CYCLE = 32'hFFFF_0000;
  localparam logic [31:0] A_TIMER = 32'hFFFF_0004;
  localparam logic [31:0] A_TSTAT = 32'hFFFF_0008;
  localparam logic [31:0] A_OUT   = 32'hFFFF_000C;
  localparam logic [31:0] A_OSTAT = 32'hFFFF_0010;

  logic        clk;
  logic        reset_n;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic exp_irq_on;

  mips_dmem_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .irq          (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: called just after a negedge; a write spans one posedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memaddr      = a;
    memwritedata = d;
    memwrite     = 1'b1;
    @(negedge clk);
    memwrite     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memaddr = a;
    #1;
    d = memreaddata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rd(A_CYCLE, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%h exp=0", v); end
    rd(A_TIMER, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_timer got=%h exp=0", v); end
    rd(A_TSTAT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_tstat got=%h exp=0", v); end
    rd(A_OSTAT, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL reset_ostat got=%h exp=2", v); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    wr(32'h0000_0040, 32'hDEAD_BEEF);
    wr(32'h0000_0044, 32'h1234_5678);
    rd(32'h0000_0040, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_read got=%h exp=deadbeef", v); end
    rd(32'h0000_0140, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_alias got=%h exp=deadbeef", v); end
    rd(32'h0000_0046, v);
    total++; if (v !== 32'h1234_5678) begin bad++; $display("FAIL ram_byte_ignore got=%h exp=12345678", v); end
    rd(32'hFFFF_0020, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL mmio_unmapped got=%h exp=0", v); end
    wr(32'hFFFF_0020, 32'hFFFF_FFFF);
    rd(32'h0000_0040, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mmio_wr_no_ram got=%h exp=deadbeef", v); end
    rd(A_OUT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL out_data_read got=%h exp=0", v); end
  endtask

  task automatic test_cycle();
    logic [31:0] c0, c1;
    @(negedge clk);
    rd(A_CYCLE, c0);
    repeat (10) @(negedge clk);
    rd(A_CYCLE, c1);
    total++; if (c1 - c0 !== 32'd10) begin bad++; $display("FAIL cycle_delta got=%0d exp=10", c1 - c0); end
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFC;
    @(negedge clk);
    release dut.cycle_q;
    repeat (7) @(negedge clk);
    rd(A_CYCLE, c1);
    total++; if (!(c1 >= 32'd1 && c1 <= 32'd8)) begin bad++; $display("FAIL cycle_wrap got=%h exp=small wrapped value", c1); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    @(negedge clk);
    wr(A_TIMER, 32'd3);
    rd(A_TIMER, v);
    total++; if (v !== 32'd3) begin bad++; $display("FAIL timer_load got=%0d exp=3", v); end
    rd(A_TSTAT, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL tstat_running got=%h exp=2", v); end
    @(negedge clk);
    rd(A_TIMER, v);
    total++; if (v !== 32'd2) begin bad++; $display("FAIL timer_dec got=%0d exp=2", v); end
    @(negedge clk);
    rd(A_TSTAT, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL tstat_before_exp got=%h exp=2", v); end
    @(negedge clk);
    rd(A_TSTAT, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL tstat_expired got=%h exp=1", v); end
    rd(A_TIMER, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL timer_zero got=%0d exp=0", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_not_yet got=%b exp=0", irq); end
    @(negedge clk);
    #1;
    total++; if (irq !== exp_irq_on) begin bad++; $display("FAIL irq_rise got=%b exp=%b", irq, exp_irq_on); end
    wr(A_TSTAT, 32'h1);
    rd(A_TSTAT, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL tstat_w1c got=%h exp=0", v); end
    total++; if (irq !== exp_irq_on) begin bad++; $display("FAIL irq_hold got=%b exp=%b", irq, exp_irq_on); end
    @(negedge clk);
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
    // reload while running, then stop with 0
    @(negedge clk);
    wr(A_TIMER, 32'd5);
    wr(A_TIMER, 32'd2);
    rd(A_TIMER, v);
    total++; if (v !== 32'd2) begin bad++; $display("FAIL timer_reload got=%0d exp=2", v); end
    @(negedge clk);
    wr(A_TIMER, 32'd0);
    repeat (4) @(negedge clk);
    rd(A_TSTAT, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL timer_stop_no_exp got=%h exp=0", v); end
  endtask

  task automatic test_fifo();
    logic [31:0] v;
    logic [31:0] exp_q[$];
    @(negedge clk);
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(A_OUT, 32'(i));
    rd(A_OSTAT, v);
    total++; if (v !== 32'h0000_0401) begin bad++; $display("FAIL fifo_full_stat got=%h exp=00000401", v); end
    wr(A_OUT, 32'd5);
    rd(A_OSTAT, v);
    total++; if (v !== 32'h0000_0405) begin bad++; $display("FAIL fifo_overflow got=%h exp=00000405", v); end
    total++; if (tx_data !== 32'd1) begin bad++; $display("FAIL fifo_head got=%0d exp=1", tx_data); end
    // push into full FIFO while the head pops
    tx_ready = 1'b1;
    wr(A_OUT, 32'd9);
    rd(A_OSTAT, v);
    total++; if (v !== 32'h0000_0405) begin bad++; $display("FAIL fifo_push_pop_full got=%h exp=00000405", v); end
    exp_q = '{32'd2, 32'd3, 32'd4, 32'd9};
    while (exp_q.size() > 0) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
        bad++; $display("FAIL fifo_drain got=%b/%0d exp=1/%0d", tx_valid, tx_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
      #1;
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_empty_valid got=%b exp=0", tx_valid); end
    rd(A_OSTAT, v);
    total++; if (v !== 32'h0000_0006) begin bad++; $display("FAIL fifo_empty_stat got=%h exp=00000006", v); end
    @(negedge clk);
    wr(A_OSTAT, 32'h4);
    rd(A_OSTAT, v);
    total++; if (v !== 32'h0000_0002) begin bad++; $display("FAIL ovf_w1c got=%h exp=00000002", v); end
    // push and pop on an empty FIFO: push lands, nothing pops
    wr(A_OUT, 32'd7);
    #1;
    total++; if (tx_valid !== 1'b1 || tx_data !== 32'd7) begin bad++; $display("FAIL fifo_empty_push_pop got=%b/%0d exp=1/7", tx_valid, tx_data); end
    @(negedge clk);
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_single_pop got=%b exp=0", tx_valid); end
    // plain fill then drain
    tx_ready = 1'b0;
    @(negedge clk);
    wr(A_OUT, 32'hA0);
    wr(A_OUT, 32'hB0);
    tx_ready = 1'b1;
    #1;
    total++; if (tx_data !== 32'hA0) begin bad++; $display("FAIL fifo_fwft_a got=%h exp=a0", tx_data); end
    @(negedge clk);
    #1;
    total++; if (tx_data !== 32'hB0) begin bad++; $display("FAIL fifo_fwft_b got=%h exp=b0", tx_data); end
    @(negedge clk);
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_drained got=%b exp=0", tx_valid); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    @(negedge clk);
    tx_ready = 1'b0;
    wr(A_TIMER, 32'd1);
    repeat (2) @(negedge clk);
    wr(A_TIMER, 32'd100);
    wr(A_OUT, 32'h11);
    wr(A_OUT, 32'h22);
    #1;
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b exp=1", tx_valid); end
    total++; if (irq !== exp_irq_on) begin bad++; $display("FAIL pre_reset_irq got=%b exp=%b", irq, exp_irq_on); end
    #1;
    reset_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL async_tx_valid got=%b exp=0", tx_valid); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_irq got=%b exp=0", irq); end
    rd(A_TIMER, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL async_timer got=%0d exp=0", v); end
    rd(A_CYCLE, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL async_cycle got=%h exp=0", v); end
    rd(A_TSTAT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL async_tstat got=%h exp=0", v); end
    rd(32'h0000_0040, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL async_ram_kept got=%h exp=deadbeef", v); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
`ifdef DMEM_TIMER_IRQ_EN
    exp_irq_on = 1'b1;
`else
    exp_irq_on = 1'b0;
`endif
    reset_n      = 1'b0;
    memwrite     = 1'b0;
    memaddr      = 32'd0;
    memwritedata = 32'd0;
    tx_ready     = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_ram();
    test_cycle();
    test_timer();
    test_fifo();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
